// File: rtl/mesh_term_src_fifo.sv
// Terminal-side source FIFO feeding one mesh terminal port (first-word fall-through).
// Optional capture of the last dropped packet when TERM_FIFO_OVF_CAPTURE_EN is defined.
module mesh_term_src_fifo #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [pckg_sz-1:0]            din,
  input  logic                          popin,
  input  logic                          clr_flags,
  output logic [pckg_sz-1:0]            data_out_i_in,
  output logic                          pndng_i_in,
  output logic                          full,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          overflow,
  output logic                          underflow,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   sent_cnt,
  output logic [$clog2(fifo_depth):0]   high_water
`ifdef TERM_FIFO_OVF_CAPTURE_EN
  ,
  output logic [pckg_sz-1:0]            ovf_data
`endif
);

  localparam int unsigned PtrW = $clog2(fifo_depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] LastIdx  = PtrW'(fifo_depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(fifo_depth);

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PtrW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CntW-1:0]    count_q, count_d, hw_q, hw_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic [15:0]        drop_q, drop_d, sent_q, sent_d;

  logic empty, is_full, pop_vld, push_vld, drop_evt, unf_evt;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    is_full  = (count_q == DepthCnt);
    pop_vld  = popin && !empty;
    // A full FIFO still accepts a push when the mesh frees a slot on the same edge.
    push_vld = push && (!is_full || pop_vld);
    drop_evt = push && !push_vld;
    unf_evt  = popin && empty;

    wp_d    = push_vld ? inc_ptr(wp_q) : wp_q;
    rp_d    = pop_vld ? inc_ptr(rp_q) : rp_q;
    count_d = count_q;
    if (push_vld && !pop_vld) count_d = count_q + CntW'(1);
    if (!push_vld && pop_vld) count_d = count_q - CntW'(1);

    // Set events override a same-cycle clear.
    ovf_d  = (ovf_q && !clr_flags) || drop_evt;
    unf_d  = (unf_q && !clr_flags) || unf_evt;
    drop_d = clr_flags ? 16'd0 : drop_q;
    if (drop_evt) drop_d = clr_flags ? 16'd1 : sat_inc(drop_q);
    sent_d = clr_flags ? 16'd0 : sent_q;
    if (pop_vld) sent_d = clr_flags ? 16'd1 : sat_inc(sent_q);
    if (clr_flags) hw_d = count_d;
    else           hw_d = (count_d > hw_q) ? count_d : hw_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      hw_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      drop_q  <= '0;
      sent_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      hw_q    <= hw_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      drop_q  <= drop_d;
      sent_q  <= sent_d;
    end
  end

  // Storage is not reset; count gates the visible head instead.
  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wp_q] <= din;
  end

  always_comb begin
    data_out_i_in = empty ? '0 : mem_q[rp_q];
    pndng_i_in    = !empty;
    full          = is_full;
    count         = count_q;
    overflow      = ovf_q;
    underflow     = unf_q;
    drop_cnt      = drop_q;
    sent_cnt      = sent_q;
    high_water    = hw_q;
  end

`ifdef TERM_FIFO_OVF_CAPTURE_EN
  logic [pckg_sz-1:0] ovf_data_q, ovf_data_d;

  always_comb begin
    ovf_data_d = clr_flags ? '0 : ovf_data_q;
    if (drop_evt) ovf_data_d = din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_data_q <= '0;
    else        ovf_data_q <= ovf_data_d;
  end

  assign ovf_data = ovf_data_q;
`endif

endmodule

// File: doc/mesh_term_src_fifo.md
# mesh_term_src_fifo

- Terminal-side source FIFO that feeds one terminal port of the 4x4 `mesh_gnrtr` mesh.
- Buffers packets pushed by the test agent and presents the head packet to the mesh as `data_out_i_in`/`pndng_i_in`; the mesh consumes with `popin`.
- Keeps sticky overflow/underflow flags, drop and sent counters and an occupancy high-water mark.
- One instance per terminal, 16 in the full environment, between the driver and the DUT.

## Interface
Parameters:
- `pckg_sz`, 40: packet width in bits.
- `fifo_depth`, 4: number of entries; legal range 2..256, any integer (not restricted to powers of two).

Ports:
- `clk`  in  1  single clock; every register is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `push`  in  1  write request from the agent.
- `din`  in  pckg_sz  packet to write.
- `popin`  in  1  pop request from the mesh terminal.
- `clr_flags`  in  1  synchronous clear of `overflow`, `underflow`, `drop_cnt`, `sent_cnt`, `high_water`.
- `data_out_i_in`  out  pckg_sz  head packet.
- `pndng_i_in`  out  1  FIFO not empty.
- `full`  out  1  count == fifo_depth.
- `count`  out  $clog2(fifo_depth)+1  current occupancy.
- `overflow`  out  1  sticky: a push was dropped.
- `underflow`  out  1  sticky: a pop arrived while the FIFO was empty.
- `drop_cnt`  out  16  dropped pushes; saturates at 16'hFFFF.
- `sent_cnt`  out  16  packets popped by the mesh; saturates at 16'hFFFF.
- `high_water`  out  $clog2(fifo_depth)+1  maximum `count` since reset or `clr_flags`.
- `ovf_data`  out  pckg_sz  only with the macro; last dropped packet.

## Operation
Storage and pointers:
- Circular buffer `mem[fifo_depth]` with write pointer `wp`, read pointer `rp` and occupancy `count`.
- Each pointer wraps from fifo_depth-1 to 0.

Outputs from state:
- `data_out_i_in` = `mem[rp]`, combinational from registered state (first-word fall-through).
- When empty, `data_out_i_in` is 0.
- `pndng_i_in` = (count != 0).

Per-edge decision, with full/empty taken from the pre-edge `count`:
- Pop valid = `popin` && !empty.
  - rp advances.
  - `sent_cnt`++ (saturating).
- Push valid = `push` && (!full || pop valid).
  - mem[wp] ← din; wp advances.
  - Push while full with a simultaneous valid pop is accepted, and count stays at fifo_depth.
- Push while full with no valid pop:
  - `din` is dropped.
  - `overflow` ← 1; `drop_cnt`++ (saturating).
- `popin` while empty:
  - No pointer change.
  - `underflow` ← 1.
  - Push and pop on an empty FIFO: the push is accepted; the pop is the underflow case.
- count_next = count + push valid − pop valid.
- `high_water` ← max(high_water, count_next).

`clr_flags`:
- Clears the flags, counters and high-water mark.
- A set event in the same cycle has priority:
  - the flag is set;
  - the counter becomes 1;
  - `high_water` becomes count_next.
- Does not touch FIFO contents or pointers.

Reset (asserted low, asynchronous):
- wp, rp, count, flags, counters and `high_water` go to 0.
- `data_out_i_in` = 0 and `pndng_i_in` = 0 immediately, without waiting for a clock edge.
- Memory contents need not be cleared.
- Reset during a transfer discards every entry.
- Deassertion is synchronous to `clk`; the first push is honoured on the first rising edge after `reset` goes high.

## Timing
- Push to visibility: 1 cycle. A push to an empty FIFO at edge N raises `pndng_i_in` and presents the packet after edge N. There is no same-cycle bypass.
- Pop: the mesh samples `data_out_i_in` while `popin` = 1. After the edge, the next entry (or 0) is presented.
- Back-to-back pops at one packet per cycle are supported.
- `full` and `count` update after the edge that changes occupancy.
- Flags, counters and `ovf_data` update on the same edge as the causing event.

## Configuration
- Macro: `TERM_FIFO_OVF_CAPTURE_EN`.
- Defined:
  - `ovf_data` port exists.
  - `ovf_data` ← `din` on every dropped push; it holds the last dropped packet.
  - `ovf_data` is 0 after reset and after `clr_flags`, unless a drop occurs in that same cycle.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use fifo_depth=4 and pckg_sz=40.
- Fill and drain:
  - Stimulus: push 40'h01..40'h04 on consecutive cycles, then `popin` for 4 cycles.
  - Required: `full`=1 and `count`=4 after the 4th push. Mesh reads 01,02,03,04 in order. `pndng_i_in`=0 after the last pop. `sent_cnt`=4, `high_water`=4.
- Overflow:
  - Stimulus: with the FIFO full, push 40'hAA with `popin`=0.
  - Required: `overflow`=1, `drop_cnt`=1, `count`=4, head still 40'h01. With the macro, `ovf_data`=40'hAA.
- Full push+pop:
  - Stimulus: with the FIFO full, push 40'h05 with `popin`=1.
  - Required: `count` stays 4, no overflow. Drained order is 02,03,04,05, which exercises pointer wrap.
- Underflow:
  - Stimulus: `popin` on an empty FIFO, then `clr_flags` on the next cycle.
  - Required: `underflow`=1, counters unchanged. After the clear, `underflow`=0.
- Mid-operation reset:
  - Stimulus: with 3 entries stored, pulse `reset` low between edges.
  - Required: immediately `pndng_i_in`=0, `count`=0, all flags and counters 0. A subsequent push of 40'hFF_0000_0001 (broadcast header) appears at the head 1 cycle later.
- Saturation:
  - Stimulus: force 65 540 drops.
  - Required: `drop_cnt` holds at 16'hFFFF.
